bats_controller: RTL and testbench



---
 rtl/bats_controller.sv | 213 +++++++++++++++++++++
 tb/tb_bats_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bats_controller.sv
// -----------------------------------------------------------------------------
// bats_controller
//
// Sequences the bat datapath of the Pong display once per frame. During
// vertical sync it moves the left and then the right bat through one shared
// add/clamp unit. On every horizontal sync rising edge it compares the current
// scanline with each bat's top line and emits a one-clock arm pulse for the
// matching bat data generator.
//
// Optional feature (macro BATS_CPU_RIGHT_EN): the right bat is driven by the
// CPU, tracking ball_y instead of following right_up/right_down.
//
// Parameters:
//   STEP        lines moved per frame per pressed direction
//   Y_MIN       lowest legal bat top line
//   Y_MAX       highest legal bat top line
//   BAT_HEIGHT  bat height in lines (CPU tracking only)
//
// Ports:
//   clk                      pixel clock
//   reset                    synchronous, active-high reset
//   hsync, vsync             sync inputs, active-high
//   vpos[8:0]                current scanline (0..261)
//   left_up/left_down        left player controls (level, synchronised)
//   right_up/right_down      right player controls (level, synchronised)
//   ball_y[8:0]              ball top line (CPU tracking only)
//   left_start, right_start  one-clock arm pulses for the bat generators
//   left_y, right_y [8:0]    registered bat top lines
//   busy                     high whenever the update sequencer is active
// -----------------------------------------------------------------------------
module bats_controller #(
  parameter int STEP       = 2,
  parameter int Y_MIN      = 8,
  parameter int Y_MAX      = 216,
  parameter int BAT_HEIGHT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [8:0] vpos,
  input  logic       left_up,
  input  logic       left_down,
  input  logic       right_up,
  input  logic       right_down,
  input  logic [8:0] ball_y,
  output logic       left_start,
  output logic       right_start,
  output logic [8:0] left_y,
  output logic [8:0] right_y,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    MOVE_L,
    MOVE_R
  } state_t;

  // Mover arithmetic is 10 bits wide so that y - STEP can be detected as
  // having wrapped below zero, and y + STEP cannot overflow.
  localparam logic [9:0] STEP_W  = 10'(STEP);
  localparam logic [9:0] Y_MIN_W = 10'(Y_MIN);
  localparam logic [9:0] Y_MAX_W = 10'(Y_MAX);
  localparam logic [8:0] Y_RESET = 9'((Y_MIN + Y_MAX) / 2);

  state_t     state;
  state_t     state_next;

  logic       hsync_d;
  logic       vsync_d;
  logic       hs_rise;
  logic       vs_rise;

  // Controls frozen for the whole update: {left_up, left_down, right_up, right_down}
  logic [3:0] ctl_q;

  logic       load_ctl;
  logic       write_left;
  logic       write_right;

  logic       mv_up;
  logic       mv_down;
  logic [8:0] mv_y;
  logic [9:0] y_ext;
  logic [9:0] y_dec;
  logic [9:0] y_inc;
  logic [8:0] mv_result;

  assign hs_rise = hsync & ~hsync_d;
  assign vs_rise = vsync & ~vsync_d;
  assign busy    = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next  = state;
    load_ctl    = 1'b0;
    write_left  = 1'b0;
    write_right = 1'b0;
    unique case (state)
      IDLE:   if (vs_rise) state_next = SAMPLE;
      SAMPLE: begin
        load_ctl   = 1'b1;
        state_next = MOVE_L;
      end
      MOVE_L: begin
        write_left = 1'b1;
        state_next = MOVE_R;
      end
      MOVE_R: begin
        write_right = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Right bat direction source
  // ---------------------------------------------------------------------------
`ifdef BATS_CPU_RIGHT_EN
  logic [8:0] ball_q;
  logic [9:0] right_center;
  logic       cpu_up;
  logic       cpu_down;

  // The CPU chases the ball with the bat's centre line.
  assign right_center = {1'b0, right_y} + 10'(BAT_HEIGHT / 2);
  assign cpu_up       = ({1'b0, ball_q} < right_center);
  assign cpu_down     = ({1'b0, ball_q} > right_center);

  always_ff @(posedge clk) begin
    if (reset) begin
      ball_q <= '0;
    end else if (load_ctl) begin
      ball_q <= ball_y;
    end
  end
`else
  // Ball position and bat height only matter for CPU tracking.
  logic unused_cfg;
  assign unused_cfg = ^{ball_y, (BAT_HEIGHT != 0)};
`endif

  // ---------------------------------------------------------------------------
  // Shared mover: operand select, then add/subtract with clamping
  // ---------------------------------------------------------------------------
  always_comb begin
    mv_y    = left_y;
    mv_up   = ctl_q[3];
    mv_down = ctl_q[2];
    if (state == MOVE_R) begin
      mv_y = right_y;
`ifdef BATS_CPU_RIGHT_EN
      mv_up   = cpu_up;
      mv_down = cpu_down;
`else
      mv_up   = ctl_q[1];
      mv_down = ctl_q[0];
`endif
    end
  end

  assign y_ext = {1'b0, mv_y};
  assign y_dec = y_ext - STEP_W;
  assign y_inc = y_ext + STEP_W;

  always_comb begin
    mv_result = mv_y;
    if (mv_up && !mv_down) begin
      // A wrap below zero shows up as y_ext < STEP_W; treat it like y < Y_MIN.
      if ((y_ext < STEP_W) || (y_dec < Y_MIN_W)) mv_result = Y_MIN_W[8:0];
      else                                        mv_result = y_dec[8:0];
    end else if (mv_down && !mv_up) begin
      if (y_inc > Y_MAX_W) mv_result = Y_MAX_W[8:0];
      else                 mv_result = y_inc[8:0];
    end
  end

  // ---------------------------------------------------------------------------
  // State, edge-detect, control, position and start-pulse registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // here sees the pre-clock values of the others. That is also why the start
  // comparison in the clock that writes a position uses the old position.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hsync_d     <= 1'b0;
      vsync_d     <= 1'b0;
      ctl_q       <= '0;
      left_y      <= Y_RESET;
      right_y     <= Y_RESET;
      left_start  <= 1'b0;
      right_start <= 1'b0;
    end else begin
      state       <= state_next;
      hsync_d     <= hsync;
      vsync_d     <= vsync;
      left_start  <= hs_rise && (vpos == left_y);
      right_start <= hs_rise && (vpos == right_y);
      if (load_ctl)    ctl_q   <= {left_up, left_down, right_up, right_down};
      if (write_left)  left_y  <= mv_result;
      if (write_right) right_y <= mv_result;
    end
  end

endmodule

// File: tb/tb_bats_controller.sv
// -----------------------------------------------------------------------------
// tb_bats_controller
//
// Self-checking bench for bats_controller. A behavioural model keeps the two
// bat positions as plain integers and moves them once per frame with the
// add/clamp rule; the frame task derives the expected cycle-by-cycle busy,
// position and start-pulse values from that model.
// -----------------------------------------------------------------------------
module tb_bats_controller;

  localparam int STEP       = 2;
  localparam int Y_MIN      = 8;
  localparam int Y_MAX      = 216;
  localparam int BAT_HEIGHT = 16;
  localparam int Y_MID      = (Y_MIN + Y_MAX) / 2;

  logic       clk;
  logic       reset;
  logic       hsync;
  logic       vsync;
  logic [8:0] vpos;
  logic       left_up;
  logic       left_down;
  logic       right_up;
  logic       right_down;
  logic [8:0] ball_y;
  logic       left_start;
  logic       right_start;
  logic [8:0] left_y;
  logic [8:0] right_y;
  logic       busy;

  int total;
  int bad;

  // Model bat positions.
  int m_left;
  int m_right;

  bats_controller #(
    .STEP       (STEP),
    .Y_MIN      (Y_MIN),
    .Y_MAX      (Y_MAX),
    .BAT_HEIGHT (BAT_HEIGHT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hsync       (hsync),
    .vsync       (vsync),
    .vpos        (vpos),
    .left_up     (left_up),
    .left_down   (left_down),
    .right_up    (right_up),
    .right_down  (right_down),
    .ball_y      (ball_y),
    .left_start  (left_start),
    .right_start (right_start),
    .left_y      (left_y),
    .right_y     (right_y),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test done");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int move(input int y, input bit up, input bit dn);
    if (up && !dn) return (y - STEP < Y_MIN) ? Y_MIN : y - STEP;
    if (dn && !up) return (y + STEP > Y_MAX) ? Y_MAX : y + STEP;
    return y;
  endfunction

  function automatic int cpu_move(input int y, input int ball);
    int c;
    c = y + BAT_HEIGHT / 2;
    return move(y, ball < c, ball > c);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    hsync = 1'b0;
    vsync = 1'b0;
    {left_up, left_down, right_up, right_down} = 4'b0;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    m_left  = Y_MID;
    m_right = Y_MID;
    check("rst_left_y", 32'(left_y), Y_MID);
    check("rst_right_y", 32'(right_y), Y_MID);
    check("rst_busy", 32'(busy), 0);
    check("rst_left_start", 32'(left_start), 0);
    check("rst_right_start", 32'(right_start), 0);
  endtask

  // One frame update. ctl = {left_up, left_down, right_up, right_down} held
  // through SAMPLE, then replaced by ctl_late. hs_phase (-1 = none) places an
  // hsync rising edge on clock N+hs_phase, N being the vs_rise clock, with
  // vpos = hs_v. re_vs raises vsync again so a second rise lands mid-update.
  task automatic run_frame(input logic [3:0] ctl, input logic [3:0] ctl_late,
                           input int hs_phase, input logic [8:0] hs_v,
                           input bit re_vs);
    int old_l, old_r, new_l, new_r, l_pre;
    old_l = m_left;
    old_r = m_right;
    new_l = move(old_l, ctl[3], ctl[2]);
`ifdef BATS_CPU_RIGHT_EN
    new_r = cpu_move(old_r, int'(ball_y));
`else
    new_r = move(old_r, ctl[1], ctl[0]);
`endif
    @(negedge clk);
    {left_up, left_down, right_up, right_down} = ctl;
    vsync = 1'b1;
    if (hs_phase == 0) begin
      hsync = 1'b1;
      vpos  = hs_v;
    end
    for (int e = 0; e <= 4; e++) begin
      @(negedge clk);
      // State after clock N+e.
      check("busy", 32'(busy), 32'(e <= 2));
      check("left_y", 32'(left_y), (e >= 2) ? new_l : old_l);
      check("right_y", 32'(right_y), (e >= 3) ? new_r : old_r);
      l_pre = (e >= 3) ? new_l : old_l;
      check("left_start", 32'(left_start), 32'(hs_phase == e && int'(hs_v) == l_pre));
      check("right_start", 32'(right_start), 32'(hs_phase == e && int'(hs_v) == old_r));
      if (e == 0) vsync = 1'b0;
      if (e == 1) begin
        {left_up, left_down, right_up, right_down} = ctl_late;
        if (re_vs) vsync = 1'b1;
      end
      if (e == 2) vsync = 1'b0;
      if (hs_phase == e) hsync = 1'b0;
      if (hs_phase == e + 1) begin
        hsync = 1'b1;
        vpos  = hs_v;
      end
    end
    {left_up, left_down, right_up, right_down} = 4'b0;
    m_left  = new_l;
    m_right = new_r;
  endtask

  initial begin
    logic [3:0] ctl;
    logic [3:0] late;
    logic [8:0] hv;
    int         phase;
    int         sel;

    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    hsync  = 1'b0;
    vsync  = 1'b0;
    vpos   = '0;
    ball_y = 9'd120;
    {left_up, left_down, right_up, right_down} = 4'b0;

    do_reset();

`ifdef BATS_CPU_RIGHT_EN
    // Drive the right bat from 112 down to 100 by parking the ball at the top.
    ball_y = 9'd0;
    repeat (6) run_frame(4'b0000, 4'b0000, -1, 9'd0, 1'b0);
    check("cpu_at_100", 32'(right_y), 100);
    ball_y = 9'd108;
    run_frame(4'b0000, 4'b0000, -1, 9'd0, 1'b0);
    check("cpu_center_hold", 32'(right_y), 100);
    ball_y = 9'd150;
    run_frame(4'b0001, 4'b0000, -1, 9'd0, 1'b0);
    check("cpu_down", 32'(right_y), 102);
    do_reset();
    ball_y = 9'd120;
`endif

    // Idle frame; both bats at 112 so an hsync rise on line 112 arms both.
    run_frame(4'b0000, 4'b0000, 3, 9'd112, 1'b0);
    check("idle_left", 32'(left_y), 112);

    // Left up for three frames: 110, 108, 106.
    repeat (3) run_frame(4'b1000, 4'b1000, -1, 9'd0, 1'b0);
    check("left_up3", 32'(left_y), 106);

    // Saturation at both ends, then one more frame pushing into the limit.
    repeat (60) run_frame(4'b0001, 4'b0001, -1, 9'd0, 1'b0);
    repeat (60) run_frame(4'b1000, 4'b1000, -1, 9'd0, 1'b0);
    run_frame(4'b1001, 4'b1001, -1, 9'd0, 1'b0);
`ifndef BATS_CPU_RIGHT_EN
    check("right_sat", 32'(right_y), Y_MAX);
`endif
    check("left_sat", 32'(left_y), Y_MIN);

    // Both left controls held; right_up released after SAMPLE still counts.
    run_frame(4'b1110, 4'b0000, -1, 9'd0, 1'b0);
    run_frame(4'b1110, 4'b0000, -1, 9'd0, 1'b0);

    // hsync and vsync rising together; start compare on the left-write clock;
    // a second vsync rise while busy is ignored.
    run_frame(4'b0100, 4'b0000, 0, 9'(m_left), 1'b0);
    run_frame(4'b0100, 4'b0000, 2, 9'(m_left), 1'b1);
    run_frame(4'b0000, 4'b0000, 1, 9'(m_right), 1'b1);

    // Randomised frames.
    for (int i = 0; i < 40; i++) begin
      ctl    = 4'($urandom);
      late   = 4'($urandom);
      phase  = int'($urandom_range(0, 4)) - 1;
      sel    = int'($urandom_range(0, 2));
      hv     = (sel == 0) ? 9'(m_left) : (sel == 1) ? 9'(m_right) : 9'($urandom_range(0, 261));
      ball_y = 9'($urandom_range(0, 240));
      run_frame(ctl, late, phase, hv, 1'($urandom_range(0, 1)));
    end

    // Reset while in MOVE_L, with an hsync rise on line 112 in the same clock.
    run_frame(4'b1000, 4'b1000, -1, 9'd0, 1'b0);
    @(negedge clk);
    left_up = 1'b1;
    vsync   = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    reset = 1'b1;
    hsync = 1'b1;
    vpos  = 9'd112;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_left_y", 32'(left_y), Y_MID);
    check("midrst_right_y", 32'(right_y), Y_MID);
    check("midrst_left_start", 32'(left_start), 0);
    check("midrst_right_start", 32'(right_start), 0);
    reset   = 1'b0;
    hsync   = 1'b0;
    left_up = 1'b0;
    m_left  = Y_MID;
    m_right = Y_MID;
    @(negedge clk);
    check("postrst_busy", 32'(busy), 0);
    check("postrst_left_y", 32'(left_y), Y_MID);

    // Normal operation resumes after the mid-update reset.
    run_frame(4'b0110, 4'b0000, 0, 9'd112, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
